// File: rtl/oport_tx_pkg.sv
// Shared definitions for the oport_tx output-port transmitter:
// flit geometry, flit-type encodings, port count and FSM states.
package oport_tx_pkg;

  localparam int NPORT    = 5;
  localparam int DATAW    = 17;
  localparam int VCH      = 1;
  localparam int VCHW     = 0;

  localparam int FLITW    = DATAW + 1;
  localparam int VCW      = VCHW + 1;
  localparam int NVC      = VCH + 1;

  localparam int TYPE_MSB = 17;
  localparam int TYPE_LSB = 16;
  localparam int TYPE_W   = TYPE_MSB - TYPE_LSB + 1;
  localparam int PAYW     = FLITW - TYPE_W;

  typedef enum logic [TYPE_W-1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Flits that may open a packet (and so may win arbitration in IDLE).
  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  // Round-robin pointer increment over ports 0..4.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/oport_tx_if.sv
// Upstream request/flit bus, downstream credit/lock and flit output of
// one router output port. slave = the transmitter, master = its environment.
interface oport_tx_if;
  import oport_tx_pkg::*;

  logic [NPORT-1:0]       req;
  logic [NPORT*FLITW-1:0] idata;
  logic [NPORT*VCW-1:0]   ivch;
  logic [NPORT-1:0]       grt;
  logic [NVC-1:0]         irdy;
  logic [NVC-1:0]         ilck;
  logic [FLITW-1:0]       odata;
  logic                   ovalid;
  logic [VCW-1:0]         ovch;

  modport slave (
    input  req, idata, ivch, irdy, ilck,
    output grt, odata, ovalid, ovch
  );

  modport master (
    output req, idata, ivch, irdy, ilck,
    input  grt, odata, ovalid, ovch
  );

endinterface

// File: rtl/oport_tx_rr_arb5.sv
// Five-way round-robin search: first eligible input at or above ptr,
// wrapping 4->0. ptr is always kept in 0..4 by the caller.
module rr_arb5
  import oport_tx_pkg::*;
(
  input  logic [NPORT-1:0] elig,
  input  logic [2:0]       ptr,
  output logic [NPORT-1:0] gnt
);

  logic [3:0] pos;
  logic       found;

  // Walk the five positions starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'd5) pos = pos - 4'd5;
      if (!found && elig[pos[2:0]]) begin
        gnt[pos[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oport_tx.sv
// Output-port transmitter: arbitrates five input channels onto one
// downstream link with packet-level (wormhole) ownership and per-VC
// ready/lock, and registers the forwarded flit.
// Optional: define OPORT_TX_STAT_EN to add the flit_cnt statistics port.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no packet open; heads arbitrated round-robin from ptr
//   ST_ACTIVE | packet open for input owner on vch_r; only owner served
module oport_tx
  import oport_tx_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0
)(
  input  logic      clk,
  input  logic      rst_,
  oport_tx_if.slave bus,
  output logic      busy
`ifdef OPORT_TX_STAT_EN
  ,
  output logic [31:0] flit_cnt
`endif
);

  // Identifiers only tag the instance for trace; reject nonsense values early.
  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
    $error("oport_tx: ROUTERID and PCHID must be non-negative");
  end

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [VCW-1:0]   vch_r_q, vch_r_d;
  logic [FLITW-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic [VCW-1:0]   ovch_q, ovch_d;

  logic [FLITW-1:0] port_flit [NPORT];
  logic [VCW-1:0]   port_vc   [NPORT];
  flit_type_e       port_type [NPORT];
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] arb_gnt;
  logic [NPORT-1:0] grt_c;
  logic [2:0]       sel_idx;
  logic [FLITW-1:0] sel_flit;
  logic [VCW-1:0]   sel_vc;
  flit_type_e       sel_type;

  // Unpack the per-input buses and decide which heads may open a packet.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      port_flit[i] = bus.idata[i*FLITW +: FLITW];
      port_vc[i]   = bus.ivch[i*VCW +: VCW];
      port_type[i] = flit_type_e'(port_flit[i][TYPE_MSB:TYPE_LSB]);
      elig[i]      = bus.req[i] && is_head(port_type[i]) &&
                     bus.irdy[port_vc[i]] && !bus.ilck[port_vc[i]];
    end
  end

  rr_arb5 u_arb (
    .elig (elig),
    .ptr  (ptr_q),
    .gnt  (arb_gnt)
  );

  // Grant selection, FSM next state and next output flit.
  always_comb begin
    grt_c    = '0;
    sel_idx  = '0;
    sel_flit = '0;
    sel_vc   = '0;
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    vch_r_d  = vch_r_q;

    if (!rst_) begin
      if (state_q == ST_IDLE) grt_c = arb_gnt;
      else grt_c[owner_q] = bus.req[owner_q] & bus.irdy[vch_r_q];
    end

    for (int i = 0; i < NPORT; i++) begin
      if (grt_c[i]) begin
        sel_idx  = 3'(i);
        sel_flit = port_flit[i];
        sel_vc   = port_vc[i];
      end
    end
    sel_type = flit_type_e'(sel_flit[TYPE_MSB:TYPE_LSB]);

    if (|grt_c) begin
      if (state_q == ST_IDLE) begin
        ptr_d   = ptr_inc(sel_idx);
        vch_r_d = sel_vc;
        if (sel_type == FT_HEAD) begin
          state_d = ST_ACTIVE;
          owner_d = sel_idx;
        end
      end else begin
        // Body of an open packet travels on the VC captured at its head.
        sel_vc = vch_r_q;
        if (sel_type == FT_TAIL) state_d = ST_IDLE;
      end
    end

    ovalid_d = |grt_c;
    odata_d  = (|grt_c) ? sel_flit : '0;
    ovch_d   = (|grt_c) ? sel_vc : '0;
  end

  // FSM and output register.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      vch_r_q  <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      vch_r_q  <= vch_r_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign bus.grt    = grt_c;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ovch   = ovch_q;
  assign busy       = (state_q == ST_ACTIVE);

`ifdef OPORT_TX_STAT_EN
  logic [31:0] flit_cnt_q, flit_cnt_d;

  // Count every forwarded flit; wraps naturally at 2^32.
  always_comb begin
    flit_cnt_d = flit_cnt_q + 32'(ovalid_q);
  end

  // Statistics counter register.
  always_ff @(posedge clk) begin
    if (rst_) flit_cnt_q <= '0;
    else      flit_cnt_q <= flit_cnt_d;
  end

  assign flit_cnt = flit_cnt_q;
`endif

endmodule

// File: tb/tb_oport_tx.sv
// Directed bench for oport_tx: expected flits are queued when a grant is
// expected and matched against odata/ovch whenever ovalid is seen.
module tb_oport_tx;
  import oport_tx_pkg::*;

  typedef struct packed {
    logic [FLITW-1:0] data;
    logic [VCW-1:0]   vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  logic busy;
`ifdef OPORT_TX_STAT_EN
  logic [31:0] flit_cnt;
`endif

  oport_tx_if bus ();

  oport_tx #(.ROUTERID(0), .PCHID(0)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .bus      (bus),
    .busy     (busy)
`ifdef OPORT_TX_STAT_EN
    ,
    .flit_cnt (flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLITW-1:0] mkf(input flit_type_e t, input logic [PAYW-1:0] pl);
    return {t, pl};
  endfunction

  task automatic put(input int p, input flit_type_e t, input logic [PAYW-1:0] pl,
                     input logic [VCW-1:0] vc);
    bus.idata[p*FLITW +: FLITW] = mkf(t, pl);
    bus.ivch[p*VCW +: VCW]      = vc;
    bus.req[p]                  = 1'b1;
  endtask

  task automatic drop(input int p);
    bus.req[p] = 1'b0;
  endtask

  // Check the combinational grant, queue what should come out, advance a cycle.
  task automatic exp_grt(input string tag, input logic [NPORT-1:0] e);
    exp_t x;
    #1;
    chk(tag, 64'(bus.grt), 64'(e));
    for (int i = 0; i < NPORT; i++) begin
      if (e[i]) begin
        x.data = bus.idata[i*FLITW +: FLITW];
        x.vc   = bus.ivch[i*VCW +: VCW];
        sb.push_back(x);
      end
    end
    @(negedge clk);
  endtask

  // Output monitor: every valid flit must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ovalid === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("odata", 64'(bus.odata), 64'(e.data));
        chk("ovch", 64'(bus.ovch), 64'(e.vc));
      end
    end
  end

  initial begin
    rst_      = 1'b1;
    bus.req   = '0;
    bus.idata = '0;
    bus.ivch  = '0;
    bus.irdy  = '1;
    bus.ilck  = '0;
    @(negedge clk);

    // Reset cycle: a valid head must not be granted.
    put(0, FT_HEADTAIL, 16'h00AA, 1'b0);
    #1 chk("rst_grt", 64'(bus.grt), 64'd0);
    @(negedge clk);
    chk("rst_ovalid", 64'(bus.ovalid), 64'd0);
    chk("rst_odata", 64'(bus.odata), 64'd0);
    chk("rst_ovch", 64'(bus.ovch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
    rst_ = 1'b0;

    // Single HEADTAIL from input 0.
    exp_grt("t1_grt", 5'b00001);
    drop(0);
    chk("t1_ovalid", 64'(bus.ovalid), 64'd1);
    chk("t1_ptr", 64'(dut.ptr_q), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // Inputs 1 and 3 contend with ptr=0; input 1 holds the port until TAIL.
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    put(1, FT_HEAD, 16'h1100, 1'b0);
    put(3, FT_HEAD, 16'h3300, 1'b1);
    exp_grt("t2_head1", 5'b00010);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_owner", 64'(dut.owner_q), 64'd1);
    put(1, FT_BODY, 16'h1101, 1'b0);
    exp_grt("t2_body1", 5'b00010);
    put(1, FT_TAIL, 16'h1102, 1'b0);
    exp_grt("t2_tail1", 5'b00010);
    drop(1);
    chk("t2_idle_after_tail", 64'(busy), 64'd0);
    exp_grt("t2_head3", 5'b01000);
    chk("t2_owner3", 64'(dut.owner_q), 64'd3);
    put(3, FT_TAIL, 16'h3301, 1'b1);
    exp_grt("t2_tail3", 5'b01000);
    drop(3);
    chk("t2_busy_end", 64'(busy), 64'd0);

    // Owner 2 stalls three cycles on irdy[0].
    put(2, FT_HEAD, 16'h2200, 1'b0);
    exp_grt("t3_head", 5'b00100);
    put(2, FT_BODY, 16'h2201, 1'b0);
    exp_grt("t3_body1", 5'b00100);
    bus.irdy = 2'b10;
    put(2, FT_BODY, 16'h2202, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_grt("t3_stall_grt", 5'b00000);
      chk("t3_stall_ovalid", 64'(bus.ovalid), 64'd0);
      chk("t3_stall_busy", 64'(busy), 64'd1);
    end
    bus.irdy = 2'b11;
    exp_grt("t3_body2", 5'b00100);
    put(2, FT_TAIL, 16'h2203, 1'b0);
    exp_grt("t3_tail", 5'b00100);
    drop(2);
    chk("t3_busy_end", 64'(busy), 64'd0);

    // BODY in IDLE is never granted.
    put(0, FT_BODY, 16'h0B0B, 1'b0);
    exp_grt("idle_body", 5'b00000);
    drop(0);

    // Input 4 blocked by ilck[0], then granted; ptr wraps to 0.
    bus.ilck = 2'b01;
    put(4, FT_HEAD, 16'h4400, 1'b0);
    exp_grt("t4_lck_a", 5'b00000);
    exp_grt("t4_lck_b", 5'b00000);
    bus.ilck = 2'b00;
    exp_grt("t4_head", 5'b10000);
    chk("t4_ptr_wrap", 64'(dut.ptr_q), 64'd0);
    bus.ilck = 2'b01;
    put(4, FT_TAIL, 16'h4401, 1'b0);
    exp_grt("t4_tail_lck_ignored", 5'b10000);
    drop(4);
    bus.ilck = 2'b00;

    // Reset in the middle of a packet after two BODY flits.
    put(0, FT_HEAD, 16'h0500, 1'b1);
    exp_grt("t5_head", 5'b00001);
    put(0, FT_BODY, 16'h0501, 1'b1);
    exp_grt("t5_body1", 5'b00001);
    put(0, FT_BODY, 16'h0502, 1'b1);
    exp_grt("t5_body2", 5'b00001);
    chk("t5_ptr_pre", 64'(dut.ptr_q), 64'd1);
    put(0, FT_BODY, 16'h0503, 1'b1);
    rst_ = 1'b1;
    exp_grt("t5_rst_grt", 5'b00000);
    rst_ = 1'b0;
    drop(0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ovalid", 64'(bus.ovalid), 64'd0);
    chk("t5_odata", 64'(bus.odata), 64'd0);
    chk("t5_ptr", 64'(dut.ptr_q), 64'd0);

`ifdef OPORT_TX_STAT_EN
    chk("t6_cnt_rst", 64'(flit_cnt), 64'd0);
    put(1, FT_HEAD, 16'h6100, 1'b0);
    exp_grt("t6_head", 5'b00010);
    put(1, FT_BODY, 16'h6101, 1'b0);
    exp_grt("t6_body1", 5'b00010);
    put(1, FT_BODY, 16'h6102, 1'b0);
    exp_grt("t6_body2", 5'b00010);
    put(1, FT_TAIL, 16'h6103, 1'b0);
    exp_grt("t6_tail", 5'b00010);
    drop(1);
    put(2, FT_HEADTAIL, 16'h6200, 1'b1);
    exp_grt("t6_ht", 5'b00100);
    drop(2);
    @(negedge clk);
    chk("t6_cnt5", 64'(flit_cnt), 64'd5);
    force dut.flit_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.flit_cnt_q;
    chk("t6_cnt_pre", 64'(flit_cnt), 64'hFFFF_FFFF);
    put(3, FT_HEADTAIL, 16'h6300, 1'b0);
    exp_grt("t6_wrap_ht", 5'b01000);
    drop(3);
    @(negedge clk);
    chk("t6_cnt_wrap", 64'(flit_cnt), 64'd0);
`endif

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
